// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between two byte-stream requesters (s0: sensor
// frames, s1: debug/echo). Ownership is granted per frame and is never
// changed mid-frame. It is released after the byte flagged "last" or after
// MAX_FRAME_LEN bytes, whichever comes first. Each accepted byte produces
// exactly one tx_start pulse. tx_data is held until the UART drops tx_busy.
//
// Build option:
//   UART_ARB_FIXED_PRIO_EN  defined   -> s0 always wins simultaneous requests
//                                        (no last-served history is kept)
//                           undefined -> round-robin at frame granularity
//
// Parameters:
//   MAX_FRAME_LEN  maximum bytes per grant before a forced release (default 64)
//
// Ports:
//   clk_in      in   system clock, rising edge
//   rst         in   synchronous reset, active high
//   s0_data     in   [7:0] requester 0 byte
//   s0_valid    in   requester 0 byte valid
//   s0_last     in   requester 0 byte ends its frame
//   s0_ready    out  requester 0 byte accepted this cycle (when valid)
//   s1_*        same as s0_* for requester 1
//   tx_data     out  [7:0] byte to the UART, stable from tx_start to busy fall
//   tx_start    out  one-cycle pulse that starts a UART byte
//   tx_busy     in   UART busy
//   grant       out  [1:0] one-hot owner (bit0 = s0, bit1 = s1), 00 when idle
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int MAX_FRAME_LEN = 64
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic [7:0] s0_data,
    input  logic       s0_valid,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic [7:0] s1_data,
    input  logic       s1_valid,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic [1:0] grant
);

    localparam int CNT_W = $clog2(MAX_FRAME_LEN) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic [1:0]       grant_r, grant_s;
    logic [7:0]       tx_data_r, tx_data_s;
    logic             tx_start_r, tx_start_s;
    logic [CNT_W-1:0] byte_cnt_r, byte_cnt_s;
    logic             last_r, last_s;
    logic             s0_ready_r, s1_ready_r;
    logic [1:0]       win_s;
    logic             sel_valid_s;
    logic [7:0]       sel_data_s;
    logic             sel_last_s;
`ifndef UART_ARB_FIXED_PRIO_EN
    // 1'b1 means s1 owned the most recently completed frame.
    logic             last_served_r, last_served_s;
`endif

    // Winner of an IDLE arbitration; only consumed when some request is valid.
    always_comb begin
        win_s = 2'b00;
`ifdef UART_ARB_FIXED_PRIO_EN
        if (s0_valid) begin
            win_s = 2'b01;
        end else begin
            win_s = 2'b10;
        end
`else
        if (s0_valid && s1_valid) begin
            // The requester that did not own the previous frame goes first.
            if (last_served_r) begin
                win_s = 2'b01;
            end else begin
                win_s = 2'b10;
            end
        end else if (s0_valid) begin
            win_s = 2'b01;
        end else begin
            win_s = 2'b10;
        end
`endif
    end

    // Byte presented by the current owner (grant is one-hot or zero).
    always_comb begin
        sel_valid_s = (grant_r[0] & s0_valid) | (grant_r[1] & s1_valid);
        if (grant_r[1]) begin
            sel_data_s = s1_data;
            sel_last_s = s1_last;
        end else begin
            sel_data_s = s0_data;
            sel_last_s = s0_last;
        end
    end

    // FSM next-state and datapath next values.
    always_comb begin
        state_s    = state_r;
        grant_s    = grant_r;
        tx_data_s  = tx_data_r;
        tx_start_s = 1'b0;
        byte_cnt_s = byte_cnt_r;
        last_s     = last_r;
`ifndef UART_ARB_FIXED_PRIO_EN
        last_served_s = last_served_r;
`endif
        case (state_r)
            IDLE: begin
                if (s0_valid || s1_valid) begin
                    grant_s = win_s;
                    state_s = LOAD;
                end else begin
                    grant_s = 2'b00;
                end
            end
            LOAD: begin
                // Ready is high for the owner throughout LOAD, so a transfer
                // is simply the owner's valid.
                if (sel_valid_s) begin
                    tx_data_s  = sel_data_s;
                    last_s     = sel_last_s;
                    byte_cnt_s = byte_cnt_r + CNT_ONE;
                    tx_start_s = 1'b1;
                    state_s    = WAIT_BUSY;
                end else begin
                    state_s = LOAD;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_s = WAIT_DONE;
                end else begin
                    state_s = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_r || (byte_cnt_r == MAX_CNT)) begin
                        // A length-forced release counts as a finished frame.
                        grant_s    = 2'b00;
                        byte_cnt_s = CNT_ZERO;
                        last_s     = 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
                        last_served_s = grant_r[1];
`endif
                        state_s    = IDLE;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            default: begin
                state_s    = IDLE;
                grant_s    = 2'b00;
                byte_cnt_s = CNT_ZERO;
                last_s     = 1'b0;
            end
        endcase
    end

    // State and datapath registers; ready is decoded from the next state so
    // it is high exactly while the FSM sits in LOAD.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_r    <= IDLE;
            grant_r    <= 2'b00;
            tx_data_r  <= 8'h00;
            tx_start_r <= 1'b0;
            byte_cnt_r <= CNT_ZERO;
            last_r     <= 1'b0;
            s0_ready_r <= 1'b0;
            s1_ready_r <= 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
            last_served_r <= 1'b1;
`endif
        end else begin
            state_r    <= state_s;
            grant_r    <= grant_s;
            tx_data_r  <= tx_data_s;
            tx_start_r <= tx_start_s;
            byte_cnt_r <= byte_cnt_s;
            last_r     <= last_s;
            s0_ready_r <= (state_s == LOAD) && grant_s[0];
            s1_ready_r <= (state_s == LOAD) && grant_s[1];
`ifndef UART_ARB_FIXED_PRIO_EN
            last_served_r <= last_served_s;
`endif
        end
    end

    assign grant    = grant_r;
    assign tx_data  = tx_data_r;
    assign tx_start = tx_start_r;
    assign s0_ready = s0_ready_r;
    assign s1_ready = s1_ready_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter (MAX_FRAME_LEN = 4). Each scenario
// pushes the hand-computed (byte, owner) sequence into a scoreboard queue.
// A monitor pops and compares on every tx_start. A UART model raises tx_busy
// 3 cycles after tx_start and holds it for 20 cycles.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic       clk_in = 1'b0;
    logic       rst;
    logic [7:0] s0_data, s1_data;
    logic       s0_valid, s0_last, s0_ready;
    logic       s1_valid, s1_last, s1_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [1:0] grant;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] d;
        logic [1:0] g;
    } exp_t;
    typedef logic [7:0] bq_t[$];

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] held_data;
    bit         stab_en = 1'b0;

    always #5 clk_in = ~clk_in;

    uart_tx_arbiter #(.MAX_FRAME_LEN(4)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .s0_data (s0_data),
        .s0_valid(s0_valid),
        .s0_last (s0_last),
        .s0_ready(s0_ready),
        .s1_data (s1_data),
        .s1_valid(s1_valid),
        .s1_last (s1_last),
        .s1_ready(s1_ready),
        .tx_data (tx_data),
        .tx_start(tx_start),
        .tx_busy (tx_busy),
        .grant   (grant)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic exp_push(input logic [7:0] d, input logic [1:0] g);
        exp_t e;
        e.d = d;
        e.g = g;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int who, input logic v, input logic [7:0] d, input logic l);
        if (who == 0) begin
            s0_valid = v; s0_data = d; s0_last = l;
        end else begin
            s1_valid = v; s1_data = d; s1_last = l;
        end
    endtask

    // Presents a frame byte by byte. Optionally drops valid for gap_len cycles
    // before byte gap_at, checking that ownership is kept during the gap.
    task automatic send_frame(input int who, input bq_t bytes, input bit with_last,
                              input int gap_at, input int gap_len);
        logic [1:0] own;
        bit         accepted;
        own = (who == 0) ? 2'b01 : 2'b10;
        for (int i = 0; i < bytes.size(); i++) begin
            if (i == gap_at) begin
                drive(who, 1'b0, 8'h00, 1'b0);
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk_in);
                    chk("gap_grant", {30'd0, grant}, {30'd0, own});
                    chk("gap_other_ready", {31'd0, (who == 0) ? s1_ready : s0_ready}, 32'd0);
                    @(posedge clk_in);
                    #1;
                end
            end
            drive(who, 1'b1, bytes[i], with_last && (i == bytes.size() - 1));
            accepted = 1'b0;
            for (int c = 0; c < 1000 && !accepted; c++) begin
                @(negedge clk_in);
                if (((who == 0) ? s0_ready : s1_ready) == 1'b1) accepted = 1'b1;
                @(posedge clk_in);
                #1;
            end
            if (!accepted) begin
                n_cmp++;
                n_fail++;
                $display("FAIL accept_timeout: requester %0d byte %0d actual not-accepted required accepted",
                         who, i);
                drive(who, 1'b0, 8'h00, 1'b0);
                return;
            end
        end
        drive(who, 1'b0, 8'h00, 1'b0);
    endtask

    // Waits for the scoreboard to drain and the arbiter to return to idle.
    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk_in);
            if (exp_q.size() == 0 && grant == 2'b00 && !tx_busy) done = 1'b1;
        end
        chk({name, "_drained"}, {31'd0, done}, 32'd1);
        @(posedge clk_in);
        #1;
    endtask

    // UART model: busy rises 3 cycles after tx_start, lasts 20 cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk_in);
            if (tx_start) begin
                repeat (3) @(posedge clk_in);
                #1 tx_busy = 1'b1;
                repeat (20) @(posedge clk_in);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Monitor: scoreboard pops plus per-cycle protocol invariants.
    initial begin
        forever begin
            @(negedge clk_in);
            if (tx_start) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_tx_start: actual data %02h required no start", tx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("tx_data", {24'd0, tx_data}, {24'd0, mon_e.d});
                    chk("tx_grant", {30'd0, grant}, {30'd0, mon_e.g});
                end
            end
            if (tx_busy && !rst) chk("no_start_while_busy", {31'd0, tx_start}, 32'd0);
            if (s0_ready) chk("s0_ready_owner", {30'd0, grant}, 32'd1);
            if (s1_ready) chk("s1_ready_owner", {30'd0, grant}, 32'd2);
            if (rst) begin
                stab_en = 1'b0;
            end else if (tx_start) begin
                held_data = tx_data;
                stab_en   = 1'b1;
            end else if (tx_busy && stab_en) begin
                chk("tx_data_stable", {24'd0, tx_data}, {24'd0, held_data});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b1;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        repeat (4) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_s0_ready", {31'd0, s0_ready}, 32'd0);
        chk("rst_s1_ready", {31'd0, s1_ready}, 32'd0);

        // Contention right after reset: s0 wins the first one in both builds.
        exp_push(8'h11, 2'b01); exp_push(8'h12, 2'b01);
        exp_push(8'h21, 2'b10); exp_push(8'h22, 2'b10);
        @(posedge clk_in);
        #1 rst = 1'b0;
        fork
            send_frame(0, '{8'h11, 8'h12}, 1'b1, -1, 0);
            send_frame(1, '{8'h21, 8'h22}, 1'b1, -1, 0);
        join
        wait_idle("contend1", 400);

        // Single s0 frame, with the valid -> tx_start latency checked.
        exp_push(8'h55, 2'b01); exp_push(8'hAA, 2'b01); exp_push(8'h0D, 2'b01);
        fork
            send_frame(0, '{8'h55, 8'hAA, 8'h0D}, 1'b1, -1, 0);
            begin
                @(negedge clk_in);
                chk("lat_t0_start", {31'd0, tx_start}, 32'd0);
                @(posedge clk_in);
                @(negedge clk_in);
                chk("lat_t1_grant", {30'd0, grant}, 32'd1);
                chk("lat_t1_ready", {31'd0, s0_ready}, 32'd1);
                chk("lat_t1_start", {31'd0, tx_start}, 32'd0);
                @(posedge clk_in);
                @(negedge clk_in);
                chk("lat_t2_start", {31'd0, tx_start}, 32'd1);
            end
        join
        wait_idle("single", 400);

        // Second contention: s0 owned the last frame, so round-robin picks s1.
`ifdef UART_ARB_FIXED_PRIO_EN
        exp_push(8'h31, 2'b01); exp_push(8'h32, 2'b01);
        exp_push(8'h41, 2'b10); exp_push(8'h42, 2'b10);
`else
        exp_push(8'h41, 2'b10); exp_push(8'h42, 2'b10);
        exp_push(8'h31, 2'b01); exp_push(8'h32, 2'b01);
`endif
        fork
            send_frame(0, '{8'h31, 8'h32}, 1'b1, -1, 0);
            send_frame(1, '{8'h41, 8'h42}, 1'b1, -1, 0);
        join
        wait_idle("contend2", 400);

        // s0 frame with a long valid gap; it is long enough that the arbiter
        // sits in LOAD with s0_valid low. s1 waits for the whole frame.
        exp_push(8'h61, 2'b01); exp_push(8'h62, 2'b01);
        exp_push(8'h63, 2'b01); exp_push(8'h64, 2'b01);
        exp_push(8'h71, 2'b10);
        fork
            send_frame(0, '{8'h61, 8'h62, 8'h63, 8'h64}, 1'b1, 2, 40);
            begin
                repeat (5) @(posedge clk_in);
                #1;
                send_frame(1, '{8'h71}, 1'b1, -1, 0);
            end
        join
        wait_idle("gap", 600);

        // Six s0 bytes with last only on the sixth, against MAX_FRAME_LEN = 4.
        // The grant is forced off after four bytes and the tail is re-arbitrated.
        for (int i = 0; i < 4; i++) exp_push(8'h81 + 8'(i), 2'b01);
`ifdef UART_ARB_FIXED_PRIO_EN
        exp_push(8'h85, 2'b01); exp_push(8'h86, 2'b01);
        exp_push(8'h91, 2'b10); exp_push(8'h92, 2'b10);
`else
        exp_push(8'h91, 2'b10); exp_push(8'h92, 2'b10);
        exp_push(8'h85, 2'b01); exp_push(8'h86, 2'b01);
`endif
        fork
            send_frame(0, '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86}, 1'b1, -1, 0);
            begin
                repeat (5) @(posedge clk_in);
                #1;
                send_frame(1, '{8'h91, 8'h92}, 1'b1, -1, 0);
            end
        join
        wait_idle("maxlen", 800);

        // Reset while byte 2 of an s0 frame is in WAIT_DONE.
        exp_push(8'hA1, 2'b01); exp_push(8'hA2, 2'b01);
        send_frame(0, '{8'hA1, 8'hA2}, 1'b0, -1, 0);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk_in);
            if (tx_busy) seen = 1'b1;
        end
        chk("rst2_busy_seen", {31'd0, seen}, 32'd1);
        @(posedge clk_in);
        #1 rst = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        chk("rst2_grant", {30'd0, grant}, 32'd0);
        chk("rst2_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst2_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst2_s0_ready", {31'd0, s0_ready}, 32'd0);
        chk("rst2_s1_ready", {31'd0, s1_ready}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk_in);
            if (!tx_busy) seen = 1'b1;
        end
        chk("rst2_busy_fall", {31'd0, seen}, 32'd1);
        @(posedge clk_in);
        #1 rst = 1'b0;
        exp_push(8'hB1, 2'b01); exp_push(8'hB2, 2'b01);
        send_frame(0, '{8'hB1, 8'hB2}, 1'b1, -1, 0);
        wait_idle("after_rst", 400);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter MAX_FRAME_LEN, default 64: maximum bytes per granted frame before the grant is forcibly released.
REQ-002 clk_in  input  1  single system clock; all logic on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 s0_data  input  8  byte from requester 0 (sensor frame stream).
REQ-005 s0_valid  input  1  requester 0 byte valid.
REQ-006 s0_last  input  1  requester 0 byte is the last of its frame.
REQ-007 s0_ready  output  1  arbiter accepts requester 0 byte this cycle.
REQ-008 s1_data, s1_valid, s1_last, s1_ready: same widths, directions and meanings for requester 1 (debug/echo stream).
REQ-009 tx_data  output  8  byte to the UART transmitter, held stable from tx_start until tx_busy falls.
REQ-010 tx_start  output  1  one-cycle pulse that starts a UART byte.
REQ-011 tx_busy  input  1  UART transmitter busy; rises after tx_start and falls when the stop bit ends.
REQ-012 grant  output  2  one-hot current owner (bit0 = s0, bit1 = s1); 2'b00 when idle.

Function
REQ-013 FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-014 IDLE: if any sX_valid, register the winner into grant and move to LOAD next cycle; otherwise stay with grant=00.
REQ-015 Arbitration is round-robin at frame granularity: on simultaneous requests, the requester not served last wins; a single requester always wins.
REQ-016 A grant is never changed mid-frame; the other requester waits even if the owner deasserts valid.
REQ-017 LOAD: sX_ready = 1 combinationally for the granted requester only; the non-granted ready is always 0.
REQ-018 A transfer occurs when valid && ready; on transfer, latch data into tx_data and last into last_r, increment byte_cnt, pulse tx_start on the next cycle, and enter WAIT_BUSY.
REQ-019 Latency: valid seen in IDLE at cycle t -> transfer at t+1 -> tx_start high at t+2.
REQ-020 WAIT_BUSY: tx_start low; wait for tx_busy=1, then enter WAIT_DONE.
REQ-021 WAIT_DONE: wait for tx_busy=0; then, if last_r=1 or byte_cnt==MAX_FRAME_LEN, clear grant, clear byte_cnt, record the served requester and enter IDLE; otherwise enter LOAD.
REQ-022 byte_cnt width is clog2(MAX_FRAME_LEN)+1 bits and never exceeds MAX_FRAME_LEN.
REQ-023 A forced release at MAX_FRAME_LEN counts as a completed frame for round-robin; the remaining bytes are arbitrated as a new frame.
REQ-024 Exactly one tx_start is issued per accepted byte; no byte is dropped or duplicated.

Reset
REQ-025 rst=1 on a clock edge forces state=IDLE, grant=00, tx_start=0, tx_data=8'h00, byte_cnt=0, last_r=0, s0_ready=s1_ready=0, and last-served=s1 (s0 wins first contention).
REQ-026 Reset mid-frame aborts the frame immediately; the partial byte in the UART is not tracked.

Configuration
REQ-027 Macro UART_ARB_FIXED_PRIO_EN defined: s0 always wins simultaneous requests in IDLE, and the last-served register is not implemented.
REQ-028 Macro UART_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-015.
REQ-029 Frame atomicity (REQ-016) and MAX_FRAME_LEN release (REQ-021) apply in both builds.

Verification
REQ-030 Only s0 sends a 3-byte frame 0x55,0xAA,0x0D (last on 0x0D) -> three tx_start pulses with tx_data in that order, grant=01 throughout, then 00.
REQ-031 s0 and s1 both valid in the cycle after reset -> s0 frame sent first, then s1 frame; a second simultaneous contention -> s1 served first (round-robin); with UART_ARB_FIXED_PRIO_EN defined -> s0 first both times.
REQ-032 s1 requests during an s0 frame in which s0_valid drops for 10 cycles -> grant stays 01 and s1_ready stays 0 until s0_last completes.
REQ-033 MAX_FRAME_LEN=4 and s0 streams 6 bytes with no last while s1 is valid -> after 4 bytes the grant passes to s1, and s0 resumes after s1's frame.
REQ-034 rst asserted in WAIT_DONE of byte 2 -> next cycle all outputs at their reset values, and a new frame starts cleanly from IDLE.
REQ-035 Model tx_busy rising 3 cycles after tx_start and lasting 20 cycles -> tx_data stable throughout and no tx_start while tx_busy=1.
